// File: rtl/mmu_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : mmu_feeder
//  Description : Operand feeder and result drain for the 2x2 output-stationary
//                systolic MMU. Latches A and B on start, drives the skewed
//                row/column operands into the array, captures and saturates
//                the four accumulators, then serialises them to the host over
//                a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmu_feeder #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 17,
    parameter int OUT_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DATA_W-1:0] mat_a,
    input  logic [4*DATA_W-1:0] mat_b,
    output logic                clear_acc,
    output logic [DATA_W-1:0]   a_row0,
    output logic [DATA_W-1:0]   a_row1,
    output logic [DATA_W-1:0]   b_col0,
    output logic [DATA_W-1:0]   b_col1,
    input  logic [ACC_W-1:0]    c00,
    input  logic [ACC_W-1:0]    c01,
    input  logic [ACC_W-1:0]    c10,
    input  logic [ACC_W-1:0]    c11,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done
);

    // Controller states; every state other than S_IDLE reports busy.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    // Cycle counter landmarks: feeding occupies cnt 0..2, draining cnt 3..4.
    localparam logic [2:0] C_FEED_LAST  = 3'd2;
    localparam logic [2:0] C_DRAIN_LAST = 3'd4;
    localparam logic [1:0] C_IDX_LAST   = 2'd3;

    // Saturation bounds expressed at accumulator width for a signed compare.
    localparam logic signed [ACC_W-1:0] C_SAT_HI =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] C_SAT_LO =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] C_OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] C_OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    state_t                r_state;
    logic [2:0]            r_cnt;
    logic [1:0]            r_idx;
    logic [4*DATA_W-1:0]   r_mat_a;
    logic [4*DATA_W-1:0]   r_mat_b;
    logic [OUT_W-1:0]      r_res [4];
    logic [OUT_W-1:0]      r_out_data;
    logic                  r_out_valid;
    logic                  r_done;

    logic [DATA_W-1:0]     w_a00, w_a01, w_a10, w_a11;
    logic [DATA_W-1:0]     w_b00, w_b01, w_b10, w_b11;
    logic [1:0]            w_idx_next;
    logic                  w_accept;

    // Clamp a signed accumulator value into the signed host output range.
    function automatic logic [OUT_W-1:0] f_sat(input logic [ACC_W-1:0] x);
        logic signed [ACC_W-1:0] v;
        v = $signed(x);
        if (v > C_SAT_HI) begin
            f_sat = C_OUT_MAX;
        end else if (v < C_SAT_LO) begin
            f_sat = C_OUT_MIN;
        end else begin
            f_sat = x[OUT_W-1:0];
        end
    endfunction

    // Element views of the latched operands; element 00 sits in the LSBs.
    assign w_a00 = r_mat_a[0*DATA_W +: DATA_W];
    assign w_a01 = r_mat_a[1*DATA_W +: DATA_W];
    assign w_a10 = r_mat_a[2*DATA_W +: DATA_W];
    assign w_a11 = r_mat_a[3*DATA_W +: DATA_W];
    assign w_b00 = r_mat_b[0*DATA_W +: DATA_W];
    assign w_b01 = r_mat_b[1*DATA_W +: DATA_W];
    assign w_b10 = r_mat_b[2*DATA_W +: DATA_W];
    assign w_b11 = r_mat_b[3*DATA_W +: DATA_W];

    assign w_idx_next = r_idx + 2'd1;
    assign w_accept   = r_out_valid && out_ready;

    assign busy      = (r_state != S_IDLE);
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign done      = r_done;

    // Skewed operand schedule: row 1 / column 1 lag row 0 / column 0 by one
    // cycle so that each PE sees matching a/b pairs; the accumulator clear is
    // issued in the same cycle a start is accepted.
    always_comb begin
        clear_acc = 1'b0;
        a_row0    = '0;
        a_row1    = '0;
        b_col0    = '0;
        b_col1    = '0;
        if (r_state == S_IDLE) begin
            clear_acc = start;
        end
        if (r_state == S_FEED) begin
            case (r_cnt)
                3'd0: begin
                    a_row0 = w_a00;
                    b_col0 = w_b00;
                end
                3'd1: begin
                    a_row0 = w_a01;
                    a_row1 = w_a10;
                    b_col0 = w_b10;
                    b_col1 = w_b01;
                end
                3'd2: begin
                    a_row1 = w_a11;
                    b_col1 = w_b11;
                end
                default: begin
                    a_row0 = '0;
                end
            endcase
        end
    end

    // Sequencer: latch operands, walk feed and drain cycles, capture the
    // saturated results and hand them out one per accepted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_idx       <= 2'd0;
            r_mat_a     <= '0;
            r_mat_b     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_res[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mat_a <= mat_a;
                        r_mat_b <= mat_b;
                        r_cnt   <= 3'd0;
                        r_state <= S_FEED;
                    end
                end
                S_FEED: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == C_FEED_LAST) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == C_DRAIN_LAST) begin
                        // c11 settles last; all four accumulators are final here.
                        r_res[0]    <= f_sat(c00);
                        r_res[1]    <= f_sat(c01);
                        r_res[2]    <= f_sat(c10);
                        r_res[3]    <= f_sat(c11);
                        r_out_data  <= f_sat(c00);
                        r_out_valid <= 1'b1;
                        r_idx       <= 2'd0;
                        r_cnt       <= 3'd0;
                        r_state     <= S_OUT;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_OUT: begin
                    if (w_accept) begin
                        if (r_idx == C_IDX_LAST) begin
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_idx       <= 2'd0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_idx      <= w_idx_next;
                            r_out_data <= r_res[w_idx_next];
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmu_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmu_feeder
//  Description : Self-checking bench for mmu_feeder with a behavioural 2x2
//                systolic array on the feed/accumulator ports and a
//                queue-based scoreboard on the host port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmu_feeder;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 17;
    localparam int OUT_W  = 8;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [4*DATA_W-1:0] mat_a;
    logic [4*DATA_W-1:0] mat_b;
    logic                clear_acc;
    logic [DATA_W-1:0]   a_row0, a_row1, b_col0, b_col1;
    logic [ACC_W-1:0]    c00, c01, c10, c11;
    logic [OUT_W-1:0]    out_data;
    logic                out_valid;
    logic                out_ready;
    logic                busy;
    logic                done;

    int n_checks = 0;
    int n_fail   = 0;
    int sb[$];
    int n_pops = 0;
    logic             held_valid = 1'b0;
    logic [OUT_W-1:0] held_data  = '0;

    mmu_feeder #(.DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mat_a     (mat_a),
        .mat_b     (mat_b),
        .clear_acc (clear_acc),
        .a_row0    (a_row0),
        .a_row1    (a_row1),
        .b_col0    (b_col0),
        .b_col1    (b_col1),
        .c00       (c00),
        .c01       (c01),
        .c10       (c10),
        .c11       (c11),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sx8(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    function automatic logic [31:0] pk(input int x00, input int x01, input int x10, input int x11);
        return {x11[7:0], x10[7:0], x01[7:0], x00[7:0]};
    endfunction

    function automatic int ref_sat(input int x);
        int hi, lo;
        hi = (1 << (OUT_W - 1)) - 1;
        lo = -(1 << (OUT_W - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural 2x2 array: a moves east, b moves south one cycle per PE,
    // every PE accumulates the product of the operands arriving this cycle.
    logic [7:0] pa [2][2];
    logic [7:0] pb [2][2];
    int         acc [2][2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 2; j++) begin
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                    acc[i][j] <= 0;
                end
            end
        end else begin
            pa[0][0] <= a_row0;  pa[0][1] <= pa[0][0];
            pa[1][0] <= a_row1;  pa[1][1] <= pa[1][0];
            pb[0][0] <= b_col0;  pb[1][0] <= pb[0][0];
            pb[0][1] <= b_col1;  pb[1][1] <= pb[0][1];
            if (clear_acc) begin
                for (int i = 0; i < 2; i++) begin
                    for (int j = 0; j < 2; j++) begin
                        acc[i][j] <= 0;
                    end
                end
            end else begin
                acc[0][0] <= acc[0][0] + sx8(a_row0)   * sx8(b_col0);
                acc[0][1] <= acc[0][1] + sx8(pa[0][0]) * sx8(b_col1);
                acc[1][0] <= acc[1][0] + sx8(a_row1)   * sx8(pb[0][0]);
                acc[1][1] <= acc[1][1] + sx8(pa[1][0]) * sx8(pb[0][1]);
            end
        end
    end

    always_comb begin
        c00 = ACC_W'(acc[0][0]);
        c01 = ACC_W'(acc[0][1]);
        c10 = ACC_W'(acc[1][0]);
        c11 = ACC_W'(acc[1][1]);
    end

    // Monitor: pops and compares on every valid&ready, checks stability while stalled.
    always @(negedge clk) begin
        #3;
        if (!rst_n || !out_valid) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid) begin
                chk("hold_data", int'(out_data), int'(held_data));
            end
            if (out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    chk("out_data", sx8(out_data), sb.pop_front());
                end
                n_pops++;
                held_valid = 1'b0;
            end else begin
                held_valid = 1'b1;
                held_data  = out_data;
            end
        end
    end

    // Reference: C = A*B element-wise sums, saturated, emitted c00,c01,c10,c11.
    task automatic push_expected(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < 2; k++) begin
                    s += sx8(a[(2*i+k)*8 +: 8]) * sx8(b[(2*k+j)*8 +: 8]);
                end
                sb.push_back(ref_sat(s));
            end
        end
    endtask

    // Modes: 0 ready high, 1 random ready, 2 stall at idx1, 3 stray starts, 4 reset at cnt1.
    // Entered and left at negedge+2.
    task automatic run(input logic [31:0] a, input logic [31:0] b, input int mode);
        int edges, valid_edge, done_edge, stall, base;
        logic [7:0] ea0, ea1, eb0, eb1;
        for (int w = 0; w < 50 && busy; w++) @(negedge clk);
        mat_a = a;
        mat_b = b;
        start = 1'b1;
        out_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        chk("clear_acc_on_start", int'(clear_acc), 1);
        push_expected(a, b);
        edges = 0; valid_edge = -1; done_edge = -1; stall = 0; base = n_pops;
        while (edges < 60 && done_edge < 0) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges <= 5) begin
                ea0 = '0; ea1 = '0; eb0 = '0; eb1 = '0;
                case (edges - 1)
                    0: begin ea0 = a[7:0]; eb0 = b[7:0]; end
                    1: begin ea0 = a[15:8]; ea1 = a[23:16]; eb0 = b[23:16]; eb1 = b[15:8]; end
                    2: begin ea1 = a[31:24]; eb1 = b[31:24]; end
                    default: ;
                endcase
                chk("a_row0", int'(a_row0), int'(ea0));
                chk("a_row1", int'(a_row1), int'(ea1));
                chk("b_col0", int'(b_col0), int'(eb0));
                chk("b_col1", int'(b_col1), int'(eb1));
            end
            if (edges == 1) begin
                chk("busy_after_start", int'(busy), 1);
                chk("done_low_in_run", int'(done), 0);
            end
            if (out_valid && valid_edge < 0) begin
                valid_edge = edges;
                chk("valid_latency", edges, 6);
            end
            if (done) done_edge = edges;
            if (mode == 4 && edges == 2) begin
                rst_n = 1'b0;
                #1;
                chk("rst_out_valid", int'(out_valid), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_out_data", int'(out_data), 0);
                chk("rst_feeds", int'({a_row0, a_row1, b_col0, b_col1}), 0);
                chk("rst_clear_acc", int'(clear_acc), 0);
                sb.delete();
                @(negedge clk);
                rst_n = 1'b1;
                #2;
                return;
            end
            if (done_edge >= 0) break;
            #2;
            start = (mode == 3) && (edges == 2 || edges == 7);
            mat_a = $urandom;
            mat_b = $urandom;
            if (start) begin
                #1;
                chk("clear_acc_while_busy", int'(clear_acc), 0);
            end
            case (mode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (n_pops - base == 1 && stall < 3) begin
                        out_ready = 1'b0;
                        stall++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
        if (done_edge < 0) begin
            chk("done_timeout", 0, 1);
        end else begin
            if (mode == 0) chk("done_after_valid", done_edge - valid_edge, 4);
            chk("busy_at_done", int'(busy), 0);
            chk("scoreboard_drained", sb.size(), 0);
        end
        #2;
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] t2a, t2b;
        rst_n = 1'b0;
        start = 1'b0;
        mat_a = '0;
        mat_b = '0;
        out_ready = 1'b0;
        #12;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_feeds", int'({a_row0, a_row1, b_col0, b_col1}), 0);
        chk("reset_clear_acc", int'(clear_acc), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;

        t2a = pk(1, 2, 3, 4);
        t2b = pk(5, 6, 7, 8);
        run(pk(1, 2, 3, 4), pk(1, 0, 0, 1), 0);
        run(t2a, t2b, 0);
        run(pk(127, 127, 127, 127), pk(127, 127, 127, 127), 0);
        run(pk(-128, -128, -128, -128), pk(127, 127, 127, 127), 0);
        run(t2a, t2b, 2);
        run(t2a, t2b, 3);
        run(t2a, t2b, 4);
        run(t2a, t2b, 0);
        for (int r = 0; r < 20; r++) begin
            run($urandom, $urandom, $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        chk("final_busy", int'(busy), 0);
        chk("final_valid", int'(out_valid), 0);
        chk("final_scoreboard", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
